// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serial config loader with even-parity check and atomic commit to the routing mux selectors
module config_chain_loader #(
    parameter int CONFIG_WIDTH = 24,
    parameter int COUNT_WIDTH  = $clog2(CONFIG_WIDTH + 1)
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    commit,
    output logic                    busy,
    output logic                    error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] FRAME_BITS = COUNT_WIDTH'(CONFIG_WIDTH);

    logic [1:0]              state;
    logic [CONFIG_WIDTH-1:0] staging;
    logic [COUNT_WIDTH-1:0]  count;
    logic                    parity;

    // Handshake and status are pure state decodes, so bit_ready never depends on bit_valid.
    assign bit_ready = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD);
    assign error     = (state == ST_ERROR);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            staging      <= '0;
            count        <= '0;
            parity       <= 1'b0;
            config_out   <= '0;
            config_valid <= 1'b0;
            commit       <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (start) begin
                // Start always (re)opens a clean frame; a bit offered alongside it is dropped.
                state   <= ST_LOAD;
                staging <= '0;
                count   <= '0;
                parity  <= 1'b0;
            end else if (state == ST_LOAD && bit_valid) begin
                if (count < FRAME_BITS) begin
                    staging <= {staging[CONFIG_WIDTH-2:0], bit_in};
                    parity  <= parity ^ bit_in;
                    count   <= count + COUNT_WIDTH'(1);
                end else if ((parity ^ bit_in) == 1'b0) begin
                    config_out   <= staging;
                    config_valid <= 1'b1;
                    commit       <= 1'b1;
                    state        <= ST_IDLE;
                end else begin
                    state <= ST_ERROR;
                end
            end else if (state != ST_LOAD && state != ST_ERROR && state != ST_IDLE) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - table-driven self-checking bench for config_chain_loader
module tb_config_chain_loader;

    logic        clock;
    logic        nreset;
    logic        start;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [23:0] config_out;
    logic        config_valid;
    logic        commit;
    logic        busy;
    logic        error;

    int tests = 0;
    int fails = 0;
    int xfer  = 0;
    int commits = 0;
    logic prev_commit = 1'b0;

    config_chain_loader #(.CONFIG_WIDTH(24)) dut (
        .clock        (clock),
        .nreset       (nreset),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .config_out   (config_out),
        .config_valid (config_valid),
        .commit       (commit),
        .busy         (busy),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] data;
        logic        par;
        logic        stall;
        logic        exp_commit;
        logic [23:0] exp_cfg;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Transfers counted since the last start; reset clears it like the DUT counter.
    always @(posedge clock or negedge nreset) begin
        if (!nreset) xfer = 0;
        else if (start) xfer = 0;
        else if (bit_valid && bit_ready) xfer++;
    end

    always @(negedge clock) begin
        if (nreset) begin
            if (commit) begin
                commits++;
                check("commit_not_back_to_back", {31'd0, prev_commit}, 32'd0);
                check("bits_per_frame", xfer, 25);
            end
            if (!busy) check("bit_ready_outside_load", {31'd0, bit_ready}, 32'd0);
        end
        prev_commit = commit;
    end

    task automatic load_bits(input logic [23:0] data, input logic par, input int nbits, input logic stall);
        logic [24:0] frame;
        int n;
        frame = {data, par};
        start = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b0;
        tick;
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (stall) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    bit_valid = 1'b0;
                    bit_in = 1'($urandom);
                    tick;
                end
            end
            bit_in = frame[24-i];
            bit_valid = 1'b1;
            tick;
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        int c0;
        vecs[0] = '{24'hA53C0F, 1'b0, 1'b0, 1'b1, 24'hA53C0F};
        vecs[1] = '{24'h000001, 1'b0, 1'b0, 1'b0, 24'hA53C0F};
        vecs[2] = '{24'h000001, 1'b1, 1'b0, 1'b1, 24'h000001};
        vecs[3] = '{24'hFFFFFF, 1'b0, 1'b1, 1'b1, 24'hFFFFFF};
        vecs[4] = '{24'h800000, 1'b1, 1'b1, 1'b1, 24'h800000};
        vecs[5] = '{24'h123456, 1'b1, 1'b0, 1'b1, 24'h123456};
        vecs[6] = '{24'h7FFFFF, 1'b0, 1'b1, 1'b0, 24'h123456};

        nreset = 1'b0;
        start = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        #2;
        check("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
        check("rst_config_out", {8'd0, config_out}, 32'd0);
        check("rst_commit", {31'd0, commit}, 32'd0);
        tick;
        tick;
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("idle_bit_ready", {31'd0, bit_ready}, 32'd0);
            check("idle_config_out", {8'd0, config_out}, 32'd0);
            check("idle_config_valid", {31'd0, config_valid}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end
        bit_valid = 1'b0;

        for (int v = 0; v < 7; v++) begin
            load_bits(vecs[v].data, vecs[v].par, 25, vecs[v].stall);
            check($sformatf("v%0d_commit", v), {31'd0, commit}, {31'd0, vecs[v].exp_commit});
            check($sformatf("v%0d_config_out", v), {8'd0, config_out}, {8'd0, vecs[v].exp_cfg});
            check($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, ~vecs[v].exp_commit});
            check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_config_valid", v), {31'd0, config_valid}, 32'd1);
            tick;
            check($sformatf("v%0d_commit_drop", v), {31'd0, commit}, 32'd0);
        end

        // Abort after 10 bits, restart with a discarded bit, then a full frame.
        c0 = commits;
        load_bits(24'hFFFFFF, 1'b0, 10, 1'b1);
        check("abort_busy", {31'd0, busy}, 32'd1);
        load_bits(24'hFFFFFF, 1'b0, 25, 1'b1);
        check("restart_config_out", {8'd0, config_out}, 32'h00FFFFFF);
        tick;
        check("restart_single_commit", commits - c0, 1);

        // Asynchronous reset between edges mid-frame.
        load_bits(24'h5A5A5A, 1'b0, 12, 1'b0);
        #3;
        nreset = 1'b0;
        #1;
        check("async_config_out", {8'd0, config_out}, 32'd0);
        check("async_config_valid", {31'd0, config_valid}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_bit_ready", {31'd0, bit_ready}, 32'd0);
        tick;
        nreset = 1'b1;
        tick;
        load_bits(24'hA53C0F, 1'b0, 25, 1'b0);
        check("post_reset_commit", {31'd0, commit}, 32'd1);
        check("post_reset_config_out", {8'd0, config_out}, 32'h00A53C0F);
        check("post_reset_config_valid", {31'd0, config_valid}, 32'd1);
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
